spi_byte_link: RTL

Byte-level SPI slave front end between the rover's external SPI master pins and the FPGA main control block. Oversamples mode-0 SPI (CPOL=0, CPHA=0, MSB first) on sysClk, delivers each received byte as `byte_from_spi` with a one-cycle `spi_input_valid` strobe, and accepts a reply byte on `byte_to_spi`/`spi_start` for shifting out on MISO. All logic runs in the sysClk domain; SPI pins are synchronized, never used as clocks.

---
 rtl/spi_byte_link.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/spi_byte_link.sv
// spi_byte_link: mode-0 SPI slave byte front end, fully oversampled on sysClk.
// SPI pins are synchronized and edge-detected; one FSM (WAIT_IDLE/IDLE/SHIFT)
// assembles RX bytes, shifts TX bytes out on MISO and manages a one-deep
// TX holding register fed by spi_start/byte_to_spi.
module spi_byte_link #(
  parameter logic [7:0] IDLE_BYTE   = 8'h00,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       sysClk,
  input  logic       sysRst_n,
  input  logic       spi_sclk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic [7:0] byte_from_spi,
  output logic       spi_input_valid,
  input  logic [7:0] byte_to_spi,
  input  logic       spi_start,
  output logic       spi_tx_ready,
  output logic       spi_tx_underrun,
  output logic       spi_tx_drop,
  output logic       spi_frame_err
);

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    SHIFT     = 2'd2
  } state_e;

  // Synchronizer chains (index 0 samples the pin)
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;

  // Edge-detect history and registered edge/level flags
  logic sclk_hist_q;
  logic cs_hist_q;
  logic sclk_rise_q;
  logic sclk_fall_q;
  logic cs_rise_q;
  logic cs_fall_q;
  logic cs_lvl_q;
  logic mosi_q;

  logic sclk_s;
  logic cs_s;

  // FSM / datapath state
  state_e     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       seen_rise_q, seen_rise_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] hold_q, hold_d;
  logic       ready_q, ready_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       valid_q, valid_d;
  logic       underrun_q, underrun_d;
  logic       drop_q, drop_d;
  logic       ferr_q, ferr_d;
  logic       miso_q, miso_d;
  logic       load_s;

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];

  // Synchronize the asynchronous SPI pins into the sysClk domain.
  // cs_n chain resets to 0 so WAIT_IDLE only leaves on a genuinely high pin.
  always_ff @(posedge sysClk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    end
  end

  // Detect sclk/cs_n edges and register them together with aligned levels.
  always_ff @(posedge sysClk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      sclk_hist_q <= 1'b0;
      cs_hist_q   <= 1'b0;
      sclk_rise_q <= 1'b0;
      sclk_fall_q <= 1'b0;
      cs_rise_q   <= 1'b0;
      cs_fall_q   <= 1'b0;
      cs_lvl_q    <= 1'b0;
      mosi_q      <= 1'b0;
    end else begin
      sclk_hist_q <= sclk_s;
      cs_hist_q   <= cs_s;
      sclk_rise_q <= sclk_s & ~sclk_hist_q;
      sclk_fall_q <= ~sclk_s & sclk_hist_q;
      cs_rise_q   <= cs_s & ~cs_hist_q;
      cs_fall_q   <= ~cs_s & cs_hist_q;
      cs_lvl_q    <= cs_s;
      mosi_q      <= mosi_sync_q[SYNC_STAGES-1];
    end
  end

  // Next-state logic: frame FSM, RX assembly, TX shifting and holding register.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    seen_rise_d = seen_rise_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    hold_d      = hold_q;
    ready_d     = ready_q;
    rx_byte_d   = rx_byte_q;
    valid_d     = 1'b0;
    underrun_d  = 1'b0;
    drop_d      = 1'b0;
    ferr_d      = 1'b0;
    load_s      = 1'b0;

    case (state_q)
      WAIT_IDLE: begin
        // Never join a frame already in progress
        if (cs_lvl_q) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_IDLE;
        end
      end
      IDLE: begin
        if (cs_fall_q) begin
          state_d     = SHIFT;
          bit_cnt_d   = 3'd0;
          seen_rise_d = 1'b0;
          load_s      = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        // cs_n edges win over a coincident sclk edge
        if (cs_rise_q) begin
          state_d   = IDLE;
          bit_cnt_d = 3'd0;
          if (bit_cnt_q != 3'd0) begin
            ferr_d = 1'b1;
          end else begin
            ferr_d = 1'b0;
          end
        end else if (sclk_rise_q) begin
          rx_shift_d  = {rx_shift_q[6:0], mosi_q};
          bit_cnt_d   = bit_cnt_q + 3'd1;
          seen_rise_d = 1'b1;
          if (bit_cnt_q == 3'd7) begin
            rx_byte_d = {rx_shift_q[6:0], mosi_q};
            valid_d   = 1'b1;
          end else begin
            valid_d = 1'b0;
          end
        end else if (sclk_fall_q) begin
          // A fall before the first rise of the frame carries no meaning
          if (!seen_rise_q) begin
            load_s = 1'b0;
          end else if (bit_cnt_q != 3'd0) begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
          end else begin
            load_s = 1'b1;
          end
        end else begin
          state_d = SHIFT;
        end
      end
      default: begin
        state_d = WAIT_IDLE;
      end
    endcase

    // Start of a byte slot: take the holding byte or fall back to IDLE_BYTE
    if (load_s) begin
      if (!ready_q) begin
        tx_shift_d = hold_q;
        ready_d    = 1'b1;
      end else begin
        tx_shift_d = IDLE_BYTE;
        underrun_d = 1'b1;
      end
    end else begin
      underrun_d = 1'b0;
    end

    // Reply byte intake judged on the registered ready flag
    if (spi_start) begin
      if (ready_q) begin
        hold_d  = byte_to_spi;
        ready_d = 1'b0;
      end else begin
        drop_d = 1'b1;
      end
    end else begin
      drop_d = 1'b0;
    end

    if (state_d == SHIFT) begin
      miso_d = tx_shift_d[7];
    end else begin
      miso_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge sysClk or negedge sysRst_n) begin
    if (!sysRst_n) begin
      state_q     <= WAIT_IDLE;
      bit_cnt_q   <= 3'd0;
      seen_rise_q <= 1'b0;
      rx_shift_q  <= 8'h00;
      tx_shift_q  <= 8'h00;
      hold_q      <= 8'h00;
      ready_q     <= 1'b1;
      rx_byte_q   <= 8'h00;
      valid_q     <= 1'b0;
      underrun_q  <= 1'b0;
      drop_q      <= 1'b0;
      ferr_q      <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      seen_rise_q <= seen_rise_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      hold_q      <= hold_d;
      ready_q     <= ready_d;
      rx_byte_q   <= rx_byte_d;
      valid_q     <= valid_d;
      underrun_q  <= underrun_d;
      drop_q      <= drop_d;
      ferr_q      <= ferr_d;
      miso_q      <= miso_d;
    end
  end

  assign spi_miso        = miso_q;
  assign byte_from_spi   = rx_byte_q;
  assign spi_input_valid = valid_q;
  assign spi_tx_ready    = ready_q;
  assign spi_tx_underrun = underrun_q;
  assign spi_tx_drop     = drop_q;
  assign spi_frame_err   = ferr_q;

endmodule
